// File: rtl/ky32_alu_pkg.sv
// Shared definitions for the ky32 ALU arbiter: op codes, requester indices,
// arbiter lock states and the ALU evaluation function.
package ky32_alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   localparam int RQ_CORE = 0;
   localparam int RQ_HELP = 1;

   typedef enum logic [1:0] {
      ARB_FREE  = 2'b00,
      ARB_LOCK0 = 2'b01,
      ARB_LOCK1 = 2'b10
   } arb_state_t;

   // c[1:0] selects the unit, c[2] the variant, c[3] arithmetic right shift.
   function automatic logic [31:0] alu_eval(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0]  c);
      logic [31:0] r;
      case (c[1:0])
         2'b00:   r = c[2] ? (a - b) : (a + b);
         2'b01:   r = c[2] ? (a | b) : (a & b);
         2'b10:   r = c[2] ? {b[15:0], 16'h0000} : (a ^ b);
         2'b11: begin
            if (!c[2])     r = b << a[4:0];
            else if (c[3]) r = $signed(b) >>> a[4:0];
            else           r = b >> a[4:0];
         end
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ky32_alu_arb_if.sv
// Request/response bundle for the two ALU requesters (index 0 core, 1 helper).
interface ky32_alu_arb_if #(parameter int TAG_W = 4);
   logic [1:0]             rq_valid;
   logic [1:0]             rq_ready;
   logic [1:0][31:0]       rq_a;
   logic [1:0][31:0]       rq_b;
   logic [1:0][3:0]        rq_op;
   logic [1:0][TAG_W-1:0]  rq_tag;
   logic [1:0]             rq_lock;
   logic [1:0]             rs_valid;
   logic [1:0]             rs_ready;
   logic [1:0][31:0]       rs_out;
   logic [1:0]             rs_zr;
   logic [1:0][TAG_W-1:0]  rs_tag;
   logic                   busy;

   modport master (
      output rq_valid, rq_a, rq_b, rq_op, rq_tag, rq_lock, rs_ready,
      input  rq_ready, rs_valid, rs_out, rs_zr, rs_tag, busy
   );

   modport slave (
      input  rq_valid, rq_a, rq_b, rq_op, rq_tag, rq_lock, rs_ready,
      output rq_ready, rs_valid, rs_out, rs_zr, rs_tag, busy
   );
endinterface

// File: rtl/ky32_rr_lock_arb2.sv
// Two-way round-robin arbiter with a grant lock and a starvation counter
// that force-releases a lock whose owner stops issuing.
module ky32_rr_lock_arb2
   import ky32_alu_pkg::*;
#(
   parameter int LOCK_MAX = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [1:0] free,
   input  logic [1:0] lock_req,
   output logic [1:0] grant,
   output logic       busy
);

   localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

   arb_state_t state, state_nx;
   logic       ptr, ptr_nx;
   logic [7:0] cnt, cnt_nx;
   logic [1:0] elig;
   logic [1:0] grant_raw;
   logic       owner;

   assign elig  = req & free;
   assign owner = (state == ARB_LOCK1);
   assign grant = rst_n ? grant_raw : 2'b00;

   // State, pointer, starvation counter and registered busy flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ARB_FREE;
         ptr   <= 1'b0;
         cnt   <= 8'd0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         cnt   <= cnt_nx;
         busy  <= (state_nx != ARB_FREE);
      end
   end

   // Grant selection and next-state; ptr names the favoured requester.
   always_comb begin
      grant_raw = 2'b00;
      state_nx  = state;
      ptr_nx    = ptr;
      cnt_nx    = cnt;
      case (state)
         ARB_FREE: begin
            if (elig == 2'b11) grant_raw = ptr ? 2'b10 : 2'b01;
            else               grant_raw = elig;
            if (grant_raw != 2'b00) begin
               ptr_nx = grant_raw[0];
               cnt_nx = 8'd0;
               if ((grant_raw & lock_req) != 2'b00)
                  state_nx = grant_raw[1] ? ARB_LOCK1 : ARB_LOCK0;
               else
                  state_nx = ARB_FREE;
            end else begin
               state_nx = ARB_FREE;
            end
         end
         ARB_LOCK0, ARB_LOCK1: begin
            grant_raw = elig & (owner ? 2'b10 : 2'b01);
            if (grant_raw != 2'b00) begin
               cnt_nx = 8'd0;
               if ((grant_raw & lock_req) == 2'b00) begin
                  state_nx = ARB_FREE;
                  ptr_nx   = ~owner;
               end else begin
                  state_nx = state;
               end
            end else if (cnt == CNT_LAST) begin
               state_nx = ARB_FREE;
               ptr_nx   = ~owner;
               cnt_nx   = 8'd0;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         default: begin
            state_nx = ARB_FREE;
            cnt_nx   = 8'd0;
         end
      endcase
   end

endmodule

// File: rtl/ky32_alu_arb.sv
// Shares one ALU between the core issue port and the address/branch helper,
// with one registered result slot per requester.
module ky32_alu_arb
   import ky32_alu_pkg::*;
#(
   parameter int LOCK_MAX = 8,
   parameter int TAG_W    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   ky32_alu_arb_if.slave bus
);

   logic [1:0]       free;
   logic [1:0]       grant;
   logic             sel;
   logic [31:0]      res;
   logic [TAG_W-1:0] tag_sel;

   // A full slot can drain and refill in the same cycle.
   assign free = ~bus.rs_valid | bus.rs_ready;

   ky32_rr_lock_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (bus.rq_valid),
      .free     (free),
      .lock_req (bus.rq_lock),
      .grant    (grant),
      .busy     (bus.busy)
   );

   assign bus.rq_ready = grant;
   assign sel          = grant[RQ_HELP];
   assign tag_sel      = bus.rq_tag[sel];
   assign res          = alu_eval(bus.rq_a[sel], bus.rq_b[sel], bus.rq_op[sel]);

   // Result slots: load on grant, empty on handshake, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rs_valid <= 2'b00;
         bus.rs_out   <= {2{32'h0000_0000}};
         bus.rs_zr    <= 2'b00;
         bus.rs_tag   <= {(2*TAG_W){1'b0}};
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
               bus.rs_valid[i] <= 1'b1;
               bus.rs_out[i]   <= res;
               bus.rs_zr[i]    <= (res == 32'h0000_0000);
               bus.rs_tag[i]   <= tag_sel;
            end else if (bus.rs_ready[i]) begin
               bus.rs_valid[i] <= 1'b0;
            end else begin
               bus.rs_valid[i] <= bus.rs_valid[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_ky32_alu_arb.sv
// Directed plus randomized bench for ky32_alu_arb against a behavioural model.
module tb_ky32_alu_arb;
   import ky32_alu_pkg::*;

   localparam int LOCK_MAX = 8;
   localparam int TAG_W    = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   ky32_alu_arb_if #(.TAG_W(TAG_W)) bus ();

   ky32_alu_arb #(.LOCK_MAX(LOCK_MAX), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // model state: favoured requester, lock owner (-1 none), idle-lock cycles, slots
   int          m_fav;
   int          m_owner;
   int          m_idle;
   logic        m_v   [2];
   logic [31:0] m_out [2];
   logic        m_zr  [2];
   logic [3:0]  m_tag [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
      int sh;
      sh = int'(a[4:0]);
      case (op[1:0])
         2'd0: return op[2] ? a - b : a + b;
         2'd1: return op[2] ? (a | b) : (a & b);
         2'd2: return op[2] ? (b << 16) : (a ^ b);
         default: begin
            if (!op[2]) return b << sh;
            if (op[3])  return 32'($signed(b) >>> sh);
            return b >> sh;
         end
      endcase
   endfunction

   task automatic model_reset();
      m_fav = 0; m_owner = -1; m_idle = 0;
      for (int i = 0; i < 2; i++) begin
         m_v[i] = 1'b0; m_out[i] = 32'h0; m_zr[i] = 1'b0; m_tag[i] = 4'h0;
      end
   endtask

   function automatic logic [1:0] model_ready();
      logic [1:0] e, r;
      for (int i = 0; i < 2; i++)
         e[i] = bus.rq_valid[i] && (!m_v[i] || bus.rs_ready[i]);
      r = 2'b00;
      if (!rst_n)             r = 2'b00;
      else if (m_owner >= 0)  r[m_owner] = e[m_owner];
      else if (e == 2'b11)    r[m_fav] = 1'b1;
      else                    r = e;
      return r;
   endfunction

   task automatic model_step(input logic [1:0] r);
      int w;
      if (!rst_n) begin
         model_reset();
         return;
      end
      w = r[1] ? 1 : (r[0] ? 0 : -1);
      for (int i = 0; i < 2; i++) begin
         if (w == i) begin
            m_v[i]   = 1'b1;
            m_out[i] = ref_alu(bus.rq_a[i], bus.rq_b[i], bus.rq_op[i]);
            m_zr[i]  = (m_out[i] == 32'h0);
            m_tag[i] = bus.rq_tag[i];
         end else if (bus.rs_ready[i]) begin
            m_v[i] = 1'b0;
         end
      end
      if (m_owner >= 0) begin
         if (w == m_owner) begin
            m_idle = 0;
            if (!bus.rq_lock[w]) begin m_fav = 1 - m_owner; m_owner = -1; end
         end else begin
            m_idle++;
            if (m_idle == LOCK_MAX) begin m_fav = 1 - m_owner; m_owner = -1; m_idle = 0; end
         end
      end else if (w >= 0) begin
         m_fav = 1 - w;
         if (bus.rq_lock[w]) begin m_owner = w; m_idle = 0; end
      end
   endtask

   // one clock: check everything at the falling edge, then advance the model
   task automatic cycle();
      logic [1:0] r;
      @(negedge clk);
      r = model_ready();
      chk("rq_ready", bus.rq_ready, r);
      chk("rs_valid", bus.rs_valid, {m_v[1], m_v[0]});
      chk("busy", bus.busy, (m_owner >= 0));
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rs_out%0d", i), bus.rs_out[i], m_out[i]);
         chk($sformatf("rs_zr%0d", i), bus.rs_zr[i], m_zr[i]);
         chk($sformatf("rs_tag%0d", i), bus.rs_tag[i], m_tag[i]);
      end
      @(posedge clk);
      model_step(r);
      #1;
   endtask

   task automatic set_rq(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [3:0] tag, input logic lk);
      bus.rq_a[i] = a; bus.rq_b[i] = b; bus.rq_op[i] = op;
      bus.rq_tag[i] = tag; bus.rq_lock[i] = lk;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.rq_valid = 2'b00; bus.rs_ready = 2'b00; bus.rq_lock = 2'b00;
      set_rq(0, 32'h0, 32'h0, ALU_ADD, 4'h0, 1'b0);
      set_rq(1, 32'h0, 32'h0, ALU_ADD, 4'h0, 1'b0);
      model_reset();
      @(posedge clk); #1;
      cycle();
      rst_n = 1'b1;

      // single op
      set_rq(0, 32'd5, 32'd7, ALU_ADD, 4'd3, 1'b0);
      bus.rq_valid = 2'b01;
      cycle();
      bus.rq_valid = 2'b00;
      chk("single_valid", bus.rs_valid, 2'b01);
      chk("single_out", bus.rs_out[0], 32'd12);
      chk("single_zr", bus.rs_zr[0], 1'b0);
      chk("single_tag", bus.rs_tag[0], 4'd3);
      bus.rs_ready = 2'b11;
      cycle();

      // contention from a fresh reset
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      set_rq(0, 32'd9, 32'd9, ALU_SUB, 4'd1, 1'b0);
      set_rq(1, 32'd0, 32'h1234, ALU_LUI, 4'd2, 1'b0);
      bus.rq_valid = 2'b11; bus.rs_ready = 2'b11;
      cycle();
      chk("cont_zr", bus.rs_zr[0], 1'b1);
      cycle();
      chk("cont_lui", bus.rs_out[1], 32'h1234_0000);
      for (int k = 0; k < 4; k++) cycle();

      // backpressure on slot 1
      bus.rs_ready = 2'b01;
      for (int k = 0; k < 5; k++) cycle();
      bus.rs_ready = 2'b11;
      for (int k = 0; k < 3; k++) cycle();

      // helper locks for three ops, core waits
      bus.rq_valid = 2'b10;
      bus.rq_lock = 2'b10;
      cycle();
      bus.rq_valid = 2'b11;
      cycle();
      chk("lock_busy", bus.busy, 1'b1);
      bus.rq_lock = 2'b00;
      cycle();
      cycle();

      // starvation guard: core locks then goes idle
      bus.rq_valid = 2'b00; cycle();
      bus.rq_valid = 2'b01; bus.rq_lock = 2'b01;
      cycle();
      bus.rq_valid = 2'b10; bus.rq_lock = 2'b00;
      for (int k = 0; k < LOCK_MAX; k++) begin
         chk("starve_busy", bus.busy, 1'b1);
         cycle();
      end
      chk("starve_release", bus.busy, 1'b0);
      chk("starve_grant", bus.rq_ready, 2'b10);
      cycle();

      // reset with both slots full and a lock held
      bus.rq_valid = 2'b00; bus.rs_ready = 2'b11; cycle();
      bus.rs_ready = 2'b00;
      bus.rq_valid = 2'b10; cycle();
      bus.rq_valid = 2'b01; bus.rq_lock = 2'b01; cycle();
      bus.rq_valid = 2'b00; bus.rq_lock = 2'b00; cycle();
      chk("pre_rst_full", bus.rs_valid, 2'b11);
      chk("pre_rst_busy", bus.busy, 1'b1);
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      chk("rst_valid", bus.rs_valid, 2'b00);
      chk("rst_busy", bus.busy, 1'b0);
      bus.rq_valid = 2'b11; bus.rs_ready = 2'b11;
      #1;
      chk("rst_first_grant", bus.rq_ready, 2'b01);
      cycle();

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         bus.rq_valid = 2'($urandom_range(0, 3));
         bus.rs_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         for (int i = 0; i < 2; i++)
            set_rq(i, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom(),
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom(),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 4) == 0));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
